add_res_station: RTL

- Adder reservation station for the Tomasulo core.
- Sits downstream of the register alias table. It allocates station tags and accepts renamed operands (tag or value) at issue.
- It snoops the common data bus for pending operands, dispatches ready entries to a pipelined 32-bit adder, and drives the add-result broadcast (tag + value) that the alias table and the other stations consume.

---
 rtl/add_res_station.sv | 139 +++++++++++++
 1 files changed

// File: rtl/add_res_station.sv
// add_res_station: adder reservation station with CDB snooping and a pipelined 32-bit add/sub unit
module add_res_station #(
  parameter int NUM_ENTRIES = 4,
  parameter int TAG_BASE = 1,
  parameter int EXEC_LAT = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        issue_valid,
  input  logic        issue_sub,
  input  logic [3:0]  rs1_tag_in,
  input  logic [31:0] rs1_val_in,
  input  logic [3:0]  rs2_tag_in,
  input  logic [31:0] rs2_val_in,
  output logic [3:0]  add_available,
  output logic        stall,
  input  logic        mul_broadcast_valid,
  input  logic [3:0]  mul_broadcast_tag,
  input  logic [31:0] mul_broadcast_value,
  output logic        broadcast_valid,
  output logic [3:0]  broadcast_tag,
  output logic [31:0] broadcast_value
);
  localparam int IW = NUM_ENTRIES > 1 ? $clog2(NUM_ENTRIES) : 1;
  typedef enum logic [1:0] {IDLE, WAIT, READY, EXEC} state_t;
  state_t      st [NUM_ENTRIES];
  logic        sub_q [NUM_ENTRIES];
  logic [3:0]  tag1 [NUM_ENTRIES];
  logic [3:0]  tag2 [NUM_ENTRIES];
  logic [31:0] val1 [NUM_ENTRIES];
  logic [31:0] val2 [NUM_ENTRIES];
  logic [3:0]  s_tag1 [NUM_ENTRIES];
  logic [3:0]  s_tag2 [NUM_ENTRIES];
  logic [31:0] s_val1 [NUM_ENTRIES];
  logic [31:0] s_val2 [NUM_ENTRIES];
  logic [3:0]  i_tag1, i_tag2;
  logic [31:0] i_val1, i_val2;
  logic [IW-1:0] free_idx, disp_idx;
  logic        disp;
  logic        p_vld [EXEC_LAT];
  logic        p_sub [EXEC_LAT];
  logic [3:0]  p_tag [EXEC_LAT];
  logic [31:0] p_a [EXEC_LAT];
  logic [31:0] p_b [EXEC_LAT];
  // a pending tag resolves against our own result bus or the multiplier bus; the buses never share a tag
  function automatic logic [35:0] resolve(input logic [3:0] t, input logic [31:0] v);
    return (t != 4'd0 && broadcast_valid && t == broadcast_tag) ? {4'd0, broadcast_value} :
           (t != 4'd0 && mul_broadcast_valid && t == mul_broadcast_tag) ? {4'd0, mul_broadcast_value} :
           {t, v};
  endfunction
  // lowest free entry for allocation and lowest ready entry for dispatch, from current state only
  always_comb begin
    add_available = 4'd0;
    stall = 1'b1;
    free_idx = '0;
    disp = 1'b0;
    disp_idx = '0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (st[i] == IDLE) begin
        add_available = 4'(TAG_BASE + i);
        stall = 1'b0;
        free_idx = IW'(i);
      end
      if (st[i] == READY) begin
        disp = 1'b1;
        disp_idx = IW'(i);
      end
    end
  end
  // operand values as they would look after this cycle's broadcasts, for issue bypass and snooping
  always_comb begin
    {i_tag1, i_val1} = resolve(rs1_tag_in, rs1_val_in);
    {i_tag2, i_val2} = resolve(rs2_tag_in, rs2_val_in);
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      {s_tag1[i], s_val1[i]} = resolve(tag1[i], val1[i]);
      {s_tag2[i], s_val2[i]} = resolve(tag2[i], val2[i]);
    end
  end
  // entry state, adder pipe and registered result broadcast
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        st[i] <= IDLE;
        sub_q[i] <= 1'b0;
        tag1[i] <= 4'd0;
        tag2[i] <= 4'd0;
        val1[i] <= 32'd0;
        val2[i] <= 32'd0;
      end
      for (int k = 0; k < EXEC_LAT; k++) begin
        p_vld[k] <= 1'b0;
        p_sub[k] <= 1'b0;
        p_tag[k] <= 4'd0;
        p_a[k] <= 32'd0;
        p_b[k] <= 32'd0;
      end
      broadcast_valid <= 1'b0;
      broadcast_tag <= 4'd0;
      broadcast_value <= 32'd0;
    end else begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        if (st[i] == WAIT) begin
          tag1[i] <= s_tag1[i];
          val1[i] <= s_val1[i];
          tag2[i] <= s_tag2[i];
          val2[i] <= s_val2[i];
          st[i] <= (s_tag1[i] == 4'd0 && s_tag2[i] == 4'd0) ? READY : WAIT;
        end
        if (disp && disp_idx == IW'(i)) st[i] <= EXEC;
        if (p_vld[EXEC_LAT-1] && p_tag[EXEC_LAT-1] == 4'(TAG_BASE + i)) st[i] <= IDLE;
        if (issue_valid && !stall && free_idx == IW'(i)) begin
          sub_q[i] <= issue_sub;
          tag1[i] <= i_tag1;
          val1[i] <= i_val1;
          tag2[i] <= i_tag2;
          val2[i] <= i_val2;
          st[i] <= (i_tag1 == 4'd0 && i_tag2 == 4'd0) ? READY : WAIT;
        end
      end
      p_vld[0] <= disp;
      p_sub[0] <= sub_q[disp_idx];
      p_tag[0] <= 4'(TAG_BASE) + 4'(disp_idx);
      p_a[0] <= val1[disp_idx];
      p_b[0] <= val2[disp_idx];
      for (int k = 1; k < EXEC_LAT; k++) begin
        p_vld[k] <= p_vld[k-1];
        p_sub[k] <= p_sub[k-1];
        p_tag[k] <= p_tag[k-1];
        p_a[k] <= p_a[k-1];
        p_b[k] <= p_b[k-1];
      end
      broadcast_valid <= p_vld[EXEC_LAT-1];
      broadcast_tag <= p_vld[EXEC_LAT-1] ? p_tag[EXEC_LAT-1] : 4'd0;
      broadcast_value <= p_vld[EXEC_LAT-1] ?
                         (p_sub[EXEC_LAT-1] ? p_a[EXEC_LAT-1] - p_b[EXEC_LAT-1] : p_a[EXEC_LAT-1] + p_b[EXEC_LAT-1]) :
                         32'd0;
    end
  end
endmodule
